// File: rtl/uart_rx_module.sv
// UART receiver: 8N1, LSB first, idle-high line, 3-sample majority vote per bit.
// Good frames update rx_data with a one-cycle done strobe. Framing errors
// raise a one-cycle error strobe, and the byte is discarded.
module uart_rx_module #(
    parameter int unsigned CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rx_pin_in,
    input  logic       rx_en_sig,
    output logic [7:0] rx_data,
    output logic       rx_done_sig,
    output logic       rx_err_sig,
    output logic       rx_busy
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned H  = CLKS_PER_BIT / 2;

    localparam logic [CW-1:0] C_SMP0 = CW'(H - 1);
    localparam logic [CW-1:0] C_SMP1 = CW'(H);
    localparam logic [CW-1:0] C_DEC  = CW'(H + 1);
    localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic          sync1_q, rx_s_q, rx_d_q;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [1:0]    smp_q, smp_d;
    logic [7:0]    data_q, data_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          busy_q, busy_d;
    logic          start_edge;
    logic          maj;

    // Two-flop synchronizer plus one delay flop for falling-edge detection
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
            rx_d_q  <= 1'b1;
        end else begin
            sync1_q <= rx_pin_in;
            rx_s_q  <= sync1_q;
            rx_d_q  <= rx_s_q;
        end
    end

    assign start_edge = rx_d_q & ~rx_s_q;
    // Two stored samples (c=H-1, c=H) vote with the live sample at c=H+1
    assign maj = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s_q) | (smp_q[1] & rx_s_q);

    // Receive FSM state and datapath registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            smp_q   <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            smp_q   <= smp_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic: window counter, sampling, bit decisions, strobes
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        smp_d   = smp_q;
        data_d  = data_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        if (state_q == S_IDLE) begin
            cnt_d = '0;
            if (start_edge && rx_en_sig) begin
                state_d = S_START;
                cnt_d   = CW'(1);
            end
        end else begin
            cnt_d = (cnt_q == C_LAST) ? '0 : cnt_q + CW'(1);
            if (cnt_q == C_SMP0) smp_d[0] = rx_s_q;
            if (cnt_q == C_SMP1) smp_d[1] = rx_s_q;
            if (cnt_q == C_DEC) begin
                case (state_q)
                    S_START: begin
                        if (maj) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_DATA;
                            bit_d   = 3'd0;
                        end
                    end
                    S_DATA: begin
                        shift_d = {maj, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == 3'd7) state_d = S_STOP;
                    end
                    S_STOP: begin
                        state_d = S_IDLE;
                        if (maj) begin
                            data_d = shift_q;
                            done_d = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    assign rx_data     = data_q;
    assign rx_done_sig = done_q;
    assign rx_err_sig  = err_q;
    assign rx_busy     = busy_q;

endmodule
